// File: rtl/addr4u_mon_pkg.sv
// ============================================================================
// Module : addr4u_mon_pkg
// Brief  : Shared widths, health-state encoding and golden-sum helper for the
//          4-bit adder fault monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package addr4u_mon_pkg;

    localparam int OP_W  = 4;
    localparam int SUM_W = 5;
    localparam int S1_W  = 2*OP_W + SUM_W;
    localparam int S2_W  = SUM_W + 1;

    typedef enum logic [1:0] {
        HL_OK    = 2'd0,
        HL_DEG   = 2'd1,
        HL_ALARM = 2'd2
    } health_e;

    // Widen before adding so the carry lands in bit 4.
    function automatic logic [SUM_W-1:0] golden_sum(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        return SUM_W'(a) + SUM_W'(b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/addr4u_mon_slice.sv
// ============================================================================
// Module : addr4u_mon_slice
// Brief  : One valid/ready register stage; data held while stalled.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module addr4u_mon_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_ld;

    // Loads when empty or when the current beat leaves this cycle.
    assign w_ld    = !r_valid || i_ready;
    assign o_ready = w_ld;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_ld) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/addr4u_fault_monitor.sv
// ============================================================================
// Module : addr4u_fault_monitor
// Brief  : Two-stage checker for the 4-bit adder with saturating error counter
//          and OK/DEGRADED/ALARM health FSM. Define ADDR4U_MON_CORRECT_EN to
//          deliver the golden sum instead of the raw adder output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module addr4u_fault_monitor
    import addr4u_mon_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             alarm,
    output logic [1:0]       health
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_thresh  = CNT_W'(THRESH);

    logic             w_s1_valid;
    logic             w_s2_ld;
    logic [S1_W-1:0]  w_s1_data;
    logic [OP_W-1:0]  w_s1_a;
    logic [OP_W-1:0]  w_s1_b;
    logic [SUM_W-1:0] w_s1_sum;
    logic [SUM_W-1:0] w_golden;
    logic             w_err;
    logic [S2_W-1:0]  w_s2_in;
    logic [S2_W-1:0]  w_s2_data;
    logic             w_out_xfer;
    logic             w_err_xfer;
    logic [CNT_W-1:0] w_cnt_nxt;
    health_e          w_health_nxt;

    logic [CNT_W-1:0] r_cnt;
    health_e          r_health;
    logic             r_alarm;

    addr4u_mon_slice #(
        .W (S1_W)
    ) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({in_a, in_b, in_sum}),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ld),
        .o_data  (w_s1_data)
    );

    assign w_s1_a   = w_s1_data[S1_W-1 -: OP_W];
    assign w_s1_b   = w_s1_data[SUM_W +: OP_W];
    assign w_s1_sum = w_s1_data[SUM_W-1:0];
    assign w_golden = golden_sum(w_s1_a, w_s1_b);
    assign w_err    = (w_s1_sum != w_golden);

`ifdef ADDR4U_MON_CORRECT_EN
    assign w_s2_in = {w_golden, w_err};
`else
    assign w_s2_in = {w_s1_sum, w_err};
`endif

    addr4u_mon_slice #(
        .W (S2_W)
    ) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ld),
        .i_data  (w_s2_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_data)
    );

    assign out_sum    = w_s2_data[S2_W-1:1];
    assign out_err    = w_s2_data[0];
    assign w_out_xfer = out_valid && out_ready;
    assign w_err_xfer = w_out_xfer && out_err;

    // A clear that coincides with an erroneous transfer still counts that error.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = CNT_W'(w_err_xfer);
        end else if (w_err_xfer && (r_cnt != c_cnt_max)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_health_nxt = clr ? HL_OK : r_health;
        case (w_health_nxt)
            HL_OK: begin
                if (w_cnt_nxt >= c_thresh) begin
                    w_health_nxt = HL_ALARM;
                end else if (w_cnt_nxt != '0) begin
                    w_health_nxt = HL_DEG;
                end
            end
            HL_DEG: begin
                if (w_cnt_nxt >= c_thresh) begin
                    w_health_nxt = HL_ALARM;
                end
            end
            HL_ALARM: w_health_nxt = HL_ALARM;
            default:  w_health_nxt = HL_OK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_health <= HL_OK;
            r_alarm  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_health <= w_health_nxt;
            r_alarm  <= (w_health_nxt == HL_ALARM);
        end
    end

    assign err_cnt = r_cnt;
    assign health  = r_health;
    assign alarm   = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_addr4u_fault_monitor.sv
// ============================================================================
// Module : tb_addr4u_fault_monitor
// Brief  : Self-checking bench: scoreboard model plus directed and random tests.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_addr4u_fault_monitor;

    logic       clk = 1'b0;
    logic       rst_n, clr, in_valid, out_ready;
    logic [3:0] in_a, in_b;
    logic [4:0] in_sum;

    logic       in_ready, out_valid, out_err, alarm;
    logic [4:0] out_sum;
    logic [7:0] err_cnt;
    logic [1:0] health;

    logic       in_ready2, out_valid2, out_err2, alarm2;
    logic [4:0] out_sum2;
    logic [1:0] err_cnt2;
    logic [1:0] health2;

    int n_tests = 0;
    int n_fail  = 0;

    addr4u_fault_monitor #(.CNT_W(8), .THRESH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
        .err_cnt(err_cnt), .alarm(alarm), .health(health)
    );

    addr4u_fault_monitor #(.CNT_W(2), .THRESH(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .out_err(out_err2),
        .err_cnt(err_cnt2), .alarm(alarm2), .health(health2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_out(input logic [3:0] a, input logic [3:0] b,
                                           input logic [4:0] s);
`ifdef ADDR4U_MON_CORRECT_EN
        return 5'(a) + 5'(b);
`else
        return s;
`endif
    endfunction

    // ---------------- reference model (scoreboard) ----------------
    typedef struct {
        logic [4:0] sum;
        logic       err;
    } beat_t;

    beat_t q[$];
    int    m_cnt1, m_cnt2;
    bit    m_alm1, m_alm2;
    bit    have_prev;
    logic [4:0] prev_sum;
    logic       prev_err;

    function automatic int exp_health(input int cnt, input bit alm);
        return alm ? 2 : (cnt > 0 ? 1 : 0);
    endfunction

    always @(negedge clk) begin
        beat_t b;
        bit    e;
        if (!rst_n) begin
            q.delete();
            m_cnt1 = 0; m_cnt2 = 0; m_alm1 = 0; m_alm2 = 0; have_prev = 0;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_err_cnt", 32'(err_cnt), 0);
        end else begin
            chk("m_err_cnt", 32'(err_cnt), 32'(m_cnt1));
            chk("m_health", 32'(health), 32'(exp_health(m_cnt1, m_alm1)));
            chk("m_alarm", 32'(alarm), 32'(m_alm1));
            chk("m_err_cnt2", 32'(err_cnt2), 32'(m_cnt2));
            chk("m_health2", 32'(health2), 32'(exp_health(m_cnt2, m_alm2)));
            if (out_valid && q.size() == 0) chk("m_spurious_valid", 32'(out_valid), 0);
            if (have_prev) begin
                chk("m_hold_valid", 32'(out_valid), 1);
                chk("m_hold_sum", 32'(out_sum), 32'(prev_sum));
                chk("m_hold_err", 32'(out_err), 32'(prev_err));
            end
            e = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("m_underflow", 0, 1);
                end else begin
                    b = q.pop_front();
                    chk("m_out_sum", 32'(out_sum), 32'(b.sum));
                    chk("m_out_err", 32'(out_err), 32'(b.err));
                    e = b.err;
                end
            end
            if (in_valid && in_ready) begin
                b.err = (in_sum != 5'(in_a) + 5'(in_b));
                b.sum = exp_out(in_a, in_b, in_sum);
                q.push_back(b);
            end
            have_prev = out_valid && !out_ready;
            prev_sum  = out_sum;
            prev_err  = out_err;
            if (clr) begin
                m_cnt1 = int'(e); m_cnt2 = int'(e); m_alm1 = 0; m_alm2 = 0;
            end else begin
                m_cnt1 = (m_cnt1 + int'(e) > 255) ? 255 : m_cnt1 + int'(e);
                m_cnt2 = (m_cnt2 + int'(e) > 3)   ? 3   : m_cnt2 + int'(e);
            end
            if (m_cnt1 >= 4) m_alm1 = 1;
            if (m_cnt2 >= 3) m_alm2 = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
        bit ok = 0;
        in_valid = 1; in_a = a; in_b = b; in_sum = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_out();
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("wait_out_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic [4:0] s;
        logic [4:0] corr;
        logic       err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ba[3], bb[3];
        logic [4:0] bs[3];
        int         idx;
        bit         acc;

        vecs[0] = '{4'hF, 4'hF, 5'h1E, 5'h1E, 1'b0};
        vecs[1] = '{4'h3, 4'h5, 5'h0C, 5'h08, 1'b1};
        vecs[2] = '{4'h0, 4'h0, 5'h00, 5'h00, 1'b0};
        vecs[3] = '{4'hF, 4'h1, 5'h10, 5'h10, 1'b0};
        vecs[4] = '{4'h9, 4'h8, 5'h01, 5'h11, 1'b1};
        vecs[5] = '{4'h7, 4'h7, 5'h0E, 5'h0E, 1'b0};
        vecs[6] = '{4'hA, 4'h5, 5'h1F, 5'h0F, 1'b1};
        vecs[7] = '{4'h0, 4'hC, 5'h0C, 5'h0C, 1'b0};

        rst_n = 0; clr = 0; in_valid = 0; out_ready = 0;
        in_a = 0; in_b = 0; in_sum = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_sum", 32'(out_sum), 0);
        chk("reset_out_err", 32'(out_err), 0);
        chk("reset_err_cnt", 32'(err_cnt), 0);
        chk("reset_alarm", 32'(alarm), 0);
        chk("reset_health", 32'(health), 0);
        chk("reset_in_ready", 32'(in_ready), 1);

        // Two-cycle latency
        out_ready = 1;
        send(4'hF, 4'hF, 5'h1E);
        chk("lat_c1_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_c2_valid", 32'(out_valid), 1);
        chk("lat_sum", 32'(out_sum), 32'h1E);
        chk("lat_err", 32'(out_err), 0);
        @(posedge clk); #1;
        chk("lat_health", 32'(health), 0);

        // Single fault example
        send(4'h3, 4'h5, 5'h0C);
        wait_out();
`ifdef ADDR4U_MON_CORRECT_EN
        chk("fault_sum", 32'(out_sum), 32'h08);
`else
        chk("fault_sum", 32'(out_sum), 32'h0C);
`endif
        chk("fault_err", 32'(out_err), 1);
        @(posedge clk); #1;
        chk("fault_cnt", 32'(err_cnt), 1);
        chk("fault_health", 32'(health), 1);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_out();
`ifdef ADDR4U_MON_CORRECT_EN
            chk($sformatf("vec%0d_sum", i), 32'(out_sum), 32'(vecs[i].corr));
`else
            chk($sformatf("vec%0d_sum", i), 32'(out_sum), 32'(vecs[i].s));
`endif
            chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].err));
        end
        drain();

        // Four faults back-to-back reach alarm; a good beat keeps it
        pulse_clr();
        chk("clr_cnt", 32'(err_cnt), 0);
        for (int i = 0; i < 4; i++) send(4'(i), 4'h1, 5'h1F);
        drain();
        chk("four_cnt", 32'(err_cnt), 4);
        chk("four_alarm", 32'(alarm), 1);
        chk("four_health", 32'(health), 2);
        send(4'h2, 4'h2, 5'h04);
        drain();
        chk("sticky_alarm", 32'(alarm), 1);

        // Backpressure: 3 beats offered during a 5-cycle stall
        ba = '{4'h1, 4'h6, 4'hC}; bb = '{4'h2, 4'h7, 4'hD}; bs = '{5'h03, 5'h00, 5'h19};
        out_ready = 0; idx = 0;
        in_valid = 1; in_a = ba[0]; in_b = bb[0]; in_sum = bs[0];
        repeat (5) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin in_a = ba[idx]; in_b = bb[idx]; in_sum = bs[idx]; end
                else in_valid = 0;
            end
        end
        chk("bp_accepted", 32'(idx), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        out_ready = 1;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin idx++; in_valid = 0; end
        end
        chk("bp_third", 32'(idx), 3);
        drain();

        // clr with a concurrent faulty transfer, then clr alone
        pulse_clr();
        out_ready = 0;
        send(4'h4, 4'h4, 5'h09);
        @(posedge clk); #1;
        chk("clr_hold_valid", 32'(out_valid), 1);
        clr = 1; out_ready = 1;
        @(posedge clk); #1;
        clr = 0;
        chk("clr_err_cnt", 32'(err_cnt), 1);
        chk("clr_err_health", 32'(health), 1);
        pulse_clr();
        chk("clr_alone_cnt", 32'(err_cnt), 0);
        chk("clr_alone_health", 32'(health), 0);

        // Saturation on the narrow counter
        for (int i = 0; i < 6; i++) send(4'h8, 4'(i), 5'h00);
        drain();
        chk("sat_cnt2", 32'(err_cnt2), 3);
        chk("sat_alarm2", 32'(alarm2), 1);
        chk("sat_health2", 32'(health2), 2);
        chk("sat_cnt1", 32'(err_cnt), 6);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [4:0] g;
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            clr       = ($urandom_range(49, 0) == 0);
            in_a = 4'($urandom); in_b = 4'($urandom);
            g = 5'(in_a) + 5'(in_b);
            in_sum = ($urandom_range(2, 0) == 0) ? (g ^ (5'd1 << $urandom_range(4, 0))) : g;
            @(posedge clk); #1;
        end
        in_valid = 0; clr = 0;
        drain();

        // Asynchronous reset with beats in flight
        in_valid = 1; in_a = 4'h5; in_b = 4'h6; in_sum = 5'h00; out_ready = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_out_sum", 32'(out_sum), 0);
        chk("async_out_err", 32'(out_err), 0);
        chk("async_err_cnt", 32'(err_cnt), 0);
        chk("async_alarm", 32'(alarm), 0);
        chk("async_health", 32'(health), 0);
        chk("async_err_cnt2", 32'(err_cnt2), 0);
        in_valid = 0;
        @(posedge clk); #1 rst_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_valid", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
